serial_pattern_tx: RTL and testbench
====================================

// Module: serial_pattern_tx
// PURPOSE
//  Serial bit-pattern transmitter, the driving end of our serial sequence detectors.
//  Latches a WIDTH-bit pattern on a start request and drives it MSB-first on a
//  registered 1-bit line. The pattern is sent (repeat_n+1) times back-to-back.
//  Feeds the j input of detector FSMs in testbenches and in the board-level demo.
// PARAMETERS
//  WIDTH     4     pattern length in bits (>=2)
//  CNT_W     4     width of repeat_n and of the pass counter
//  IDLE_BIT  1'b1  level driven on j when no pattern is being sent
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        request; sampled only in IDLE
//  abort     in   1        synchronous cancel of an active transfer
//  pattern   in   WIDTH    bits to send, pattern[WIDTH-1] first
//  repeat_n  in   CNT_W    extra passes; total passes = repeat_n+1
//  j         out  1        serial data line (registered)
//  valid     out  1        high while j carries a pattern bit
//  busy      out  1        high from first bit through last bit
//  done      out  1        one-cycle pulse after the final bit
// BEHAVIOUR
//  Reset: state=IDLE; j=IDLE_BIT; valid=0; busy=0; done=0; internal regs cleared.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : j=IDLE_BIT. At an edge with start=1, latch pattern and repeat_n,
//          go to SHIFT. The first bit (pattern[WIDTH-1]) appears on j in the same
//          cycle that busy and valid rise, one cycle after start is sampled.
//   SHIFT: one bit per cycle, MSB first. The bit index counts WIDTH-1..0.
//          After bit 0: if the pass count < repeat_n, reload the latched pattern
//          and continue with its MSB in the next cycle (no gap). Otherwise go to DONE.
//   DONE : j=IDLE_BIT; valid=0; busy=0; done=1 for exactly this cycle.
//          Next state is IDLE. A start sampled in DONE is ignored.
//  start while busy: ignored. Latched pattern and repeat_n do not change mid-transfer.
//  abort=1 in SHIFT: next cycle goes to IDLE with j=IDLE_BIT, valid=0, busy=0.
//   done is not pulsed. abort in IDLE or DONE has no effect.
//  abort and start both high in IDLE: start wins, because abort is ignored in IDLE.
//  Async reset mid-transfer: outputs return to reset values immediately. No done.
//  Transfer length: (repeat_n+1)*WIDTH cycles of valid, then 1 done cycle.
//   Example: WIDTH=4, repeat_n=15 gives 64 bits.
//  The pass counter is CNT_W bits, compared with == against repeat_n.
//   Maximum repeat_n = 2^CNT_W-1, with no wrap.
//  All outputs come from registers. There is no combinational path from input to output.
// STRUCTURE
//  Shared package: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the
//   IDLE_BIT default, shared with the detector FSMs' bench code.
//  One natural sub-module: serial_pattern_shreg. It holds the WIDTH-bit load/shift
//   register with the bit-index counter and flags the last bit. The top level keeps
//   the FSM and the pass counter.
// TESTING
//  1. Reset, then start with pattern=4'b0101, repeat_n=0.
//     Expect j=0,1,0,1 on cycles 1-4 with valid=1, done=1 on cycle 5, then j=1.
//     A chained 0101 Moore detector asserts w exactly once.
//  2. pattern=4'b0101, repeat_n=2.
//     Expect 12 back-to-back bits 010101010101 with busy continuously high,
//     then a single done pulse. The detector shows w pulses on overlapping matches.
//  3. start pulsed again on cycle 2 of a transfer with pattern=4'b1111.
//     Expect it to be ignored: the original bits finish unchanged and one done pulse.
//  4. abort on the 3rd bit of pattern=4'b0110.
//     Expect j=0,1 then IDLE_BIT next cycle, busy=0, no done pulse.
//     A new start is accepted on the following cycle.
//  5. Async reset asserted mid-SHIFT, between clock edges.
//     Expect j=1, valid=0, busy=0 immediately, and the FSM in IDLE after release.
//  6. repeat_n=4'hF with WIDTH=4.
//     Expect exactly 64 valid cycles and a done pulse on cycle 65, with no counter wrap.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches that it drives.
// Holds the FSM state encodings and the default idle line level.
package serial_pattern_tx_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic IdleBitDefault = 1'b1;

endpackage

// File: rtl/serial_pattern_shreg.sv
// Load/shift register for the pattern transmitter.
// It keeps the latched pattern for reloads and tracks the index of the bit currently on the line.
module serial_pattern_shreg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             reload_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] pattern_i,
  output logic             next_bit_o,
  output logic             reload_bit_o,
  output logic             last_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  // sr_q holds only the bits still to come; the current bit already sits in the line register
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_comb begin
    pat_d = pat_q;
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load_i) begin
      pat_d = pattern_i;
      sr_d  = pattern_i[WIDTH-2:0];
      idx_d = LastIdx;
    end else if (reload_i) begin
      sr_d  = pat_q[WIDTH-2:0];
      idx_d = LastIdx;
    end else if (shift_i) begin
      sr_d  = sr_q << 1;
      idx_d = idx_q - IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pat_q <= '0;
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign next_bit_o   = sr_q[WIDTH-2];
  assign reload_bit_o = pat_q[WIDTH-1];
  assign last_o       = (idx_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first, repeat_n+1 times back-to-back,
// on a registered line, with valid/busy qualifiers and a one-cycle done pulse.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_BIT = IdleBitDefault
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  output logic             j_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic             j_q, j_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, reload, shift;
  logic             next_bit, reload_bit, last;

  serial_pattern_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (load),
    .reload_i    (reload),
    .shift_i     (shift),
    .pattern_i   (pattern_i),
    .next_bit_o  (next_bit),
    .reload_bit_o(reload_bit),
    .last_o      (last)
  );

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    j_d     = j_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    reload  = 1'b0;
    shift   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          load    = 1'b1;
          rep_d   = repeat_n_i;
          pass_d  = '0;
          j_d     = pattern_i[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StShift: begin
        if (abort_i) begin
          state_d = StIdle;
          j_d     = IDLE_BIT;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (!last) begin
          shift = 1'b1;
          j_d   = next_bit;
        end else if (pass_q != rep_q) begin
          // Next pass starts straight after bit 0, no idle gap
          reload = 1'b1;
          pass_d = pass_q + CNT_W'(1);
          j_d    = reload_bit;
        end else begin
          state_d = StDone;
          j_d     = IDLE_BIT;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        j_d     = IDLE_BIT;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      rep_q   <= '0;
      pass_q  <= '0;
      j_q     <= IDLE_BIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      j_q     <= j_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign j_o     = j_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed scenarios plus randomized transfers checked against
// an expected bit stream built from the pattern and repeat count.
module tb_serial_pattern_tx;

  localparam logic IdleLvl = 1'b1;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       abort_i;
  logic [3:0] pattern_i;
  logic [3:0] repeat_n_i;
  logic       j_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  serial_pattern_tx #(
    .WIDTH   (4),
    .CNT_W   (4),
    .IDLE_BIT(1'b1)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .pattern_i (pattern_i),
    .repeat_n_i(repeat_n_i),
    .j_o       (j_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ej, input logic ev, input logic eb,
                           input logic ed);
    check_eq({tag, ".j"}, 32'(j_o), 32'(ej));
    check_eq({tag, ".valid"}, 32'(valid_o), 32'(ev));
    check_eq({tag, ".busy"}, 32'(busy_o), 32'(eb));
    check_eq({tag, ".done"}, 32'(done_o), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // abort_at: index of the bit during which abort is held (-1 = never)
  task automatic run_xfer(input logic [3:0] pat, input logic [3:0] rep, input int abort_at,
                          input bit glitch, input bit abort_with_start);
    logic bits[$];
    for (int p = 0; p <= int'(rep); p++)
      for (int b = 3; b >= 0; b--) bits.push_back(pat[b]);
    start_i    = 1'b1;
    pattern_i  = pat;
    repeat_n_i = rep;
    abort_i    = abort_with_start;
    tick();
    start_i    = 1'b0;
    abort_i    = 1'b0;
    pattern_i  = 4'($urandom);
    repeat_n_i = 4'($urandom);
    for (int k = 0; k < bits.size(); k++) begin
      check_out("bit", bits[k], 1'b1, 1'b1, 1'b0);
      if (glitch && k == 1) begin
        start_i    = 1'b1;
        pattern_i  = 4'hF;
        repeat_n_i = 4'hF;
      end
      if (k == abort_at) abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      if (k == abort_at) begin
        abort_i = 1'b0;
        check_out("abort", IdleLvl, 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    // Neither abort nor start may matter in DONE
    abort_i   = 1'($urandom_range(0, 1));
    start_i   = 1'($urandom_range(0, 1));
    pattern_i = 4'($urandom);
    check_out("done", IdleLvl, 1'b0, 1'b0, 1'b1);
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    check_out("after_done", IdleLvl, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i    = 1'b1;
    start_i    = 1'b0;
    abort_i    = 1'b0;
    pattern_i  = '0;
    repeat_n_i = '0;
    #3;
    check_out("reset", IdleLvl, 1'b0, 1'b0, 1'b0);
    #9 reset_i = 1'b0;
    tick();
    check_out("idle0", IdleLvl, 1'b0, 1'b0, 1'b0);

    run_xfer(4'b0101, 4'd0, -1, 1'b0, 1'b0);
    run_xfer(4'b0101, 4'd2, -1, 1'b0, 1'b0);
    run_xfer(4'b0011, 4'd0, -1, 1'b1, 1'b0);
    run_xfer(4'b0110, 4'd0, 1, 1'b0, 1'b0);
    run_xfer(4'b1001, 4'd1, -1, 1'b0, 1'b1);
    run_xfer(4'b1011, 4'hF, -1, 1'b0, 1'b0);

    // Async reset between edges in the middle of a transfer
    start_i    = 1'b1;
    pattern_i  = 4'b1010;
    repeat_n_i = 4'd3;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #3 reset_i = 1'b1;
    #1;
    check_out("async_rst", IdleLvl, 1'b0, 1'b0, 1'b0);
    #2 reset_i = 1'b0;
    tick();
    check_out("post_rst", IdleLvl, 1'b0, 1'b0, 1'b0);
    run_xfer(4'b1100, 4'd1, -1, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [3:0] pat;
      logic [3:0] rep;
      int         ab;
      pat = 4'($urandom);
      rep = 4'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (int'(rep) + 1) * 4 - 1)) : -1;
      run_xfer(pat, rep, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_out("gap", IdleLvl, 1'b0, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
